// File: rtl/hall_sensor_conditioner.sv
// Hall sensor front end: synchronise and debounce the active-low magnet line,
// strobe on each accepted magnet arrival, and measure the revolution period.
module hall_sensor_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 1000,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 hall_raw,
  output logic                 hall_clean,
  output logic                 rev_pulse,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_strobe,
  output logic                 period_valid,
  output logic                 stalled
);

  localparam int FCNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [FCNT_W-1:0]    FCNT_LAST = FCNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {STABLE_HI = 1'b0, STABLE_LO = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic                   hall_clean_q, hall_clean_d;
  logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
  logic                   rev_pulse_q, rev_pulse_d;
  logic [CNT_WIDTH-1:0]   rev_cnt_q, rev_cnt_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic                   period_strobe_q, period_strobe_d;
  logic                   period_valid_q, period_valid_d;
  logic                   stalled_q, stalled_d;
  logic                   armed_q, armed_d;
  logic                   seen_q, seen_d;
  logic                   hall_sync;
  logic                   cnt_sat;

  assign hall_sync = sync_q[SYNC_STAGES-1];
  assign cnt_sat   = (rev_cnt_q == CNT_MAX);

  // Synchroniser shift and debounce filter: flip only after a full run of mismatches.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], hall_raw};
    state_d      = state_q;
    hall_clean_d = hall_clean_q;
    fcnt_d       = '0;
    rev_pulse_d  = 1'b0;
    case (state_q)
      STABLE_HI: begin
        if (!hall_sync) begin
          if (fcnt_q == FCNT_LAST) begin
            state_d      = STABLE_LO;
            hall_clean_d = 1'b0;
            rev_pulse_d  = 1'b1;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end else begin
          fcnt_d = '0;
        end
      end
      STABLE_LO: begin
        if (hall_sync) begin
          if (fcnt_q == FCNT_LAST) begin
            state_d      = STABLE_HI;
            hall_clean_d = 1'b1;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end else begin
          fcnt_d = '0;
        end
      end
      default: begin
        state_d      = STABLE_HI;
        hall_clean_d = 1'b1;
      end
    endcase
  end

  // Period measurement; a pulse coinciding with saturation only re-arms.
  always_comb begin
    rev_cnt_d       = rev_cnt_q;
    period_d        = period_q;
    period_strobe_d = 1'b0;
    period_valid_d  = period_valid_q;
    stalled_d       = stalled_q;
    armed_d         = armed_q;
    seen_d          = seen_q;
    if (rev_pulse_q) begin
      rev_cnt_d = CNT_ONE;
    end else if (!cnt_sat) begin
      rev_cnt_d = rev_cnt_q + CNT_ONE;
    end else begin
      rev_cnt_d = rev_cnt_q;
    end
    if (rev_pulse_q) begin
      seen_d = 1'b1;
      if (!armed_q || cnt_sat) begin
        armed_d   = 1'b1;
        stalled_d = 1'b0;
        if (cnt_sat) begin
          period_valid_d = 1'b0;
        end else begin
          period_valid_d = period_valid_q;
        end
      end else begin
        period_d        = rev_cnt_q;
        period_strobe_d = 1'b1;
        period_valid_d  = 1'b1;
      end
    end else if (cnt_sat && (armed_q || seen_q)) begin
      stalled_d      = 1'b1;
      period_valid_d = 1'b0;
      armed_d        = 1'b0;
    end else begin
      stalled_d = stalled_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q          <= {SYNC_STAGES{1'b1}};
      state_q         <= STABLE_HI;
      hall_clean_q    <= 1'b1;
      fcnt_q          <= '0;
      rev_pulse_q     <= 1'b0;
      rev_cnt_q       <= '0;
      period_q        <= '0;
      period_strobe_q <= 1'b0;
      period_valid_q  <= 1'b0;
      stalled_q       <= 1'b0;
      armed_q         <= 1'b0;
      seen_q          <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      state_q         <= state_d;
      hall_clean_q    <= hall_clean_d;
      fcnt_q          <= fcnt_d;
      rev_pulse_q     <= rev_pulse_d;
      rev_cnt_q       <= rev_cnt_d;
      period_q        <= period_d;
      period_strobe_q <= period_strobe_d;
      period_valid_q  <= period_valid_d;
      stalled_q       <= stalled_d;
      armed_q         <= armed_d;
      seen_q          <= seen_d;
    end
  end

  assign hall_clean    = hall_clean_q;
  assign rev_pulse     = rev_pulse_q;
  assign period        = period_q;
  assign period_strobe = period_strobe_q;
  assign period_valid  = period_valid_q;
  assign stalled       = stalled_q;

endmodule

// File: tb/tb_hall_sensor_conditioner.sv
// Directed bench for hall_sensor_conditioner with FILTER_CYCLES=4, SYNC_STAGES=2,
// CNT_WIDTH=8; inputs change and outputs are sampled on the falling clock edge.
module tb_hall_sensor_conditioner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       hall_raw;
  logic       hall_clean;
  logic       rev_pulse;
  logic [7:0] period;
  logic       period_strobe;
  logic       period_valid;
  logic       stalled;

  int n_checks;
  int n_pass;

  hall_sensor_conditioner #(
    .SYNC_STAGES(2),
    .FILTER_CYCLES(4),
    .CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hall_raw(hall_raw),
    .hall_clean(hall_clean),
    .rev_pulse(rev_pulse),
    .period(period),
    .period_strobe(period_strobe),
    .period_valid(period_valid),
    .stalled(stalled)
  );

  always #5 clk = ~clk;

  localparam logic [12:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

  function automatic logic [12:0] outs();
    return {hall_clean, rev_pulse, period_strobe, period_valid, stalled, period};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic apply_reset();
    hall_raw = 1'b1;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Falling edge on hall_raw held 10 cycles; next edge starts `spacing` cycles later.
  task automatic do_edge(input string tag, input int spacing, input logic exp_strobe,
                         input logic [7:0] exp_period, input logic exp_valid,
                         input logic exp_stalled);
    hall_raw = 1'b0;
    repeat (5) @(negedge clk);
    check({tag, "_pulse_early"}, rev_pulse, 0);
    check({tag, "_clean_early"}, hall_clean, 1);
    @(negedge clk);
    check({tag, "_pulse"}, rev_pulse, 1);
    check({tag, "_clean"}, hall_clean, 0);
    @(negedge clk);
    check({tag, "_strobe"}, period_strobe, exp_strobe);
    check({tag, "_period"}, period, exp_period);
    check({tag, "_valid"}, period_valid, exp_valid);
    check({tag, "_stalled"}, stalled, exp_stalled);
    @(negedge clk);
    check({tag, "_strobe_off"}, period_strobe, 0);
    check({tag, "_pulse_off"}, rev_pulse, 0);
    repeat (2) @(negedge clk);
    hall_raw = 1'b1;
    repeat (spacing - 10) @(negedge clk);
  endtask

  initial begin
    int pulses;
    int lows;
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    hall_raw = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", outs(), RST_VEC);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle", outs(), RST_VEC);
    end

    // 3-cycle glitch must be discarded
    hall_raw = 1'b0;
    repeat (3) @(negedge clk);
    hall_raw = 1'b1;
    pulses = 0;
    lows   = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pulses += int'(rev_pulse);
      lows   += int'(!hall_clean);
    end
    check("glitch3_pulses", pulses, 0);
    check("glitch3_lows", lows, 0);

    // 4-cycle low is accepted 6 clocks after the step
    hall_raw = 1'b0;
    repeat (4) @(negedge clk);
    hall_raw = 1'b1;
    @(negedge clk);
    check("g4_clean_d5", hall_clean, 1);
    @(negedge clk);
    check("g4_clean_d6", hall_clean, 0);
    check("g4_pulse_d6", rev_pulse, 1);
    @(negedge clk);
    check("g4_pulse_d7", rev_pulse, 0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      pulses += int'(rev_pulse);
    end
    check("g4_no_rise_pulse", pulses, 0);
    check("g4_clean_back", hall_clean, 1);

    // Period measurement, stall and re-arm
    apply_reset();
    do_edge("e1", 50, 1'b0, 8'd0, 1'b0, 1'b0);
    do_edge("e2", 50, 1'b1, 8'd50, 1'b1, 1'b0);
    do_edge("e3", 20, 1'b1, 8'd50, 1'b1, 1'b0);
    repeat (241) @(negedge clk);
    check("stall_before", stalled, 0);
    check("valid_before", period_valid, 1);
    @(negedge clk);
    check("stall_set", stalled, 1);
    check("stall_valid", period_valid, 0);
    check("stall_period", period, 8'd50);
    repeat (44) @(negedge clk);
    check("stall_hold", stalled, 1);
    do_edge("rearm", 60, 1'b0, 8'd50, 1'b0, 1'b0);
    do_edge("p60", 30, 1'b1, 8'd60, 1'b1, 1'b0);

    // Bouncy edge yields one pulse 4 cycles after the last 0 is synchronised
    apply_reset();
    hall_raw = 1'b0; @(negedge clk);
    hall_raw = 1'b1; @(negedge clk);
    hall_raw = 1'b0; @(negedge clk);
    hall_raw = 1'b1; @(negedge clk);
    hall_raw = 1'b0;
    pulses = 0;
    for (int k = 5; k <= 30; k++) begin
      @(negedge clk);
      pulses += int'(rev_pulse);
      if (k == 9) check("bounce_pulse_d9", rev_pulse, 0);
      if (k == 10) check("bounce_pulse_d10", rev_pulse, 1);
    end
    check("bounce_pulse_count", pulses, 1);
    hall_raw = 1'b1;
    repeat (10) @(negedge clk);

    // Reset between edges
    apply_reset();
    do_edge("m1", 20, 1'b0, 8'd0, 1'b0, 1'b0);
    do_edge("m2", 40, 1'b1, 8'd20, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_reset", outs(), RST_VEC);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    do_edge("m3", 40, 1'b0, 8'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
